// File: rtl/uart_rx_frame_assembler.sv
// Assembles UART receiver words into header/payload/checksum frames and queues
// good frames in a small FIFO presented over a valid/ready handshake.
module uart_rx_frame_assembler #(
  parameter int unsigned PAYLOAD_WORDS = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [8:0]                         rx_data,
  input  logic                               rx_done,
  input  logic                               rx_framing_error,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic [7:0]                         frame_id,
  output logic [8*PAYLOAD_WORDS-1:0]         frame_payload,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    frame_count,
  output logic                               err_sequence,
  output logic                               err_checksum,
  output logic                               err_framing,
  output logic                               err_overflow
);

  localparam int unsigned IdxW = $clog2(PAYLOAD_WORDS + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PayW = 8 * PAYLOAD_WORDS;

  localparam logic [1:0] StHunt    = 2'd0;
  localparam logic [1:0] StPayload = 2'd1;
  localparam logic [1:0] StCheck   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      csum_q, csum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PayW-1:0] pay_q, pay_d;
  logic            fe_q;
  logic            seq_q, seq_d;
  logic            chk_q, chk_d;
  logic            frm_q, frm_d;
  logic            ovf_q, ovf_d;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      id_mem  [FIFO_DEPTH];
  logic [PayW-1:0] pay_mem [FIFO_DEPTH];

  logic       fe_rise, word_ok, marker, push, push_ok, pop;
  logic [7:0] rx_byte;

  assign fe_rise = rx_framing_error & ~fe_q;
  // Words arriving while the receiver flags a framing error are untrustworthy.
  assign word_ok = rx_done & ~rx_framing_error;
  assign marker  = rx_data[8];
  assign rx_byte = rx_data[7:0];

  assign frame_valid = (count_q != '0);
  assign pop         = frame_valid & frame_ready;
  assign push_ok     = push & ((count_q < CntW'(FIFO_DEPTH)) | pop);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    seq_d   = 1'b0;
    chk_d   = 1'b0;
    frm_d   = fe_rise;
    push    = 1'b0;
    if (fe_rise) begin
      state_d = StHunt;
      idx_d   = '0;
      csum_d  = '0;
    end else if (word_ok) begin
      case (state_q)
        StHunt: begin
          if (marker) begin
            id_d    = rx_byte;
            csum_d  = rx_byte;
            idx_d   = '0;
            state_d = StPayload;
          end else begin
            seq_d = 1'b1;
          end
        end
        StPayload, StCheck: begin
          if (marker) begin
            // A header mid-frame starts a fresh frame rather than waiting for HUNT.
            seq_d   = 1'b1;
            id_d    = rx_byte;
            csum_d  = rx_byte;
            idx_d   = '0;
            state_d = StPayload;
          end else if (state_q == StPayload) begin
            for (int k = 0; k < PAYLOAD_WORDS; k++) begin
              if (idx_q == IdxW'(k)) pay_d[8*k +: 8] = rx_byte;
            end
            csum_d = csum_q ^ rx_byte;
            idx_d  = idx_q + IdxW'(1);
            if (idx_q == IdxW'(PAYLOAD_WORDS - 1)) state_d = StCheck;
          end else begin
            if (rx_byte == csum_q) push = 1'b1;
            else                   chk_d = 1'b1;
            state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StHunt;
      id_q     <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      pay_q    <= '0;
      fe_q     <= 1'b0;
      seq_q    <= 1'b0;
      chk_q    <= 1'b0;
      frm_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      csum_q   <= csum_d;
      idx_q    <= idx_d;
      pay_q    <= pay_d;
      fe_q     <= rx_framing_error;
      seq_q    <= seq_d;
      chk_q    <= chk_d;
      frm_q    <= frm_d;
      ovf_q    <= push & ~push_ok;
      count_q  <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: contents are masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      id_mem[wr_ptr_q]  <= id_q;
      pay_mem[wr_ptr_q] <= pay_q;
    end
  end

  assign frame_id      = frame_valid ? id_mem[rd_ptr_q]  : '0;
  assign frame_payload = frame_valid ? pay_mem[rd_ptr_q] : '0;
  assign frame_count   = count_q;
  assign err_sequence  = seq_q;
  assign err_checksum  = chk_q;
  assign err_framing   = frm_q;
  assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench for uart_rx_frame_assembler at default parameters.
module tb_uart_rx_frame_assembler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        rx_framing_error = 1'b0;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [7:0]  frame_id;
  logic [23:0] frame_payload;
  logic [2:0]  frame_count;
  logic        err_sequence, err_checksum, err_framing, err_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int n_seq = 0, n_chk = 0, n_frm = 0, n_ovf = 0;

  uart_rx_frame_assembler #(.PAYLOAD_WORDS(3), .FIFO_DEPTH(4)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_done          (rx_done),
    .rx_framing_error (rx_framing_error),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .frame_id         (frame_id),
    .frame_payload    (frame_payload),
    .frame_count      (frame_count),
    .err_sequence     (err_sequence),
    .err_checksum     (err_checksum),
    .err_framing      (err_framing),
    .err_overflow     (err_overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err_sequence) n_seq++;
    if (err_checksum) n_chk++;
    if (err_framing)  n_frm++;
    if (err_overflow) n_ovf++;
  end

  task automatic clear_errs();
    n_seq = 0; n_chk = 0; n_frm = 0; n_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one word for exactly one clock; consecutive calls are back-to-back.
  task automatic send(input logic [8:0] w);
    rx_data = w;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] p0,
                            input logic [7:0] p1, input logic [7:0] p2);
    send({1'b1, id});
    send({1'b0, p0});
    send({1'b0, p1});
    send({1'b0, p2});
    send({1'b0, id ^ p0 ^ p1 ^ p2});
  endtask

  task automatic pop_one();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", frame_valid); end
    n_cmp++; if (frame_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", frame_count); end
    n_cmp++; if (frame_id !== 8'h00) begin n_bad++; $display("FAIL rst_id: got 0x%0h expected 0", frame_id); end
    n_cmp++; if ({err_sequence, err_checksum, err_framing, err_overflow} !== 4'b0) begin
      n_bad++; $display("FAIL rst_errs: got %b expected 0000",
                        {err_sequence, err_checksum, err_framing, err_overflow});
    end
    reset_n = 1'b1;
    tick();
    clear_errs();
  endtask

  task automatic test_good_frame();
    clear_errs();
    send(9'h1A5); send(9'h012); send(9'h034); send(9'h056); send(9'h0D5);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %b expected 1", frame_valid); end
    n_cmp++; if (frame_id !== 8'hA5) begin n_bad++; $display("FAIL good_id: got 0x%0h expected 0xa5", frame_id); end
    n_cmp++; if (frame_payload !== 24'h563412) begin n_bad++; $display("FAIL good_payload: got 0x%0h expected 0x563412", frame_payload); end
    n_cmp++; if (frame_count !== 3'd1) begin n_bad++; $display("FAIL good_count: got %0d expected 1", frame_count); end
    tick();
    n_cmp++; if (n_seq + n_chk + n_frm + n_ovf != 0) begin n_bad++; $display("FAIL good_errs: got %0d pulses expected 0", n_seq + n_chk + n_frm + n_ovf); end
    pop_one();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL good_pop_valid: got %b expected 0", frame_valid); end
  endtask

  task automatic test_bad_checksum();
    clear_errs();
    send(9'h1A5); send(9'h012); send(9'h034); send(9'h056); send(9'h0D4);
    n_cmp++; if (err_checksum !== 1'b1) begin n_bad++; $display("FAIL chk_pulse: got %b expected 1", err_checksum); end
    tick();
    n_cmp++; if (err_checksum !== 1'b0) begin n_bad++; $display("FAIL chk_pulse_end: got %b expected 0", err_checksum); end
    n_cmp++; if (n_chk != 1) begin n_bad++; $display("FAIL chk_count: got %0d expected 1", n_chk); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL chk_valid: got %b expected 0", frame_valid); end
  endtask

  task automatic test_resync();
    clear_errs();
    send(9'h1A5); send(9'h012);
    send(9'h1B0); send(9'h001); send(9'h002); send(9'h003); send(9'h0B0);
    n_cmp++; if (frame_id !== 8'hB0) begin n_bad++; $display("FAIL resync_id: got 0x%0h expected 0xb0", frame_id); end
    n_cmp++; if (frame_payload !== 24'h030201) begin n_bad++; $display("FAIL resync_payload: got 0x%0h expected 0x030201", frame_payload); end
    n_cmp++; if (frame_count !== 3'd1) begin n_bad++; $display("FAIL resync_count: got %0d expected 1", frame_count); end
    n_cmp++; if (n_seq != 1) begin n_bad++; $display("FAIL resync_seq: got %0d expected 1", n_seq); end
    pop_one();
    clear_errs();
    send(9'h055);
    n_cmp++; if (err_sequence !== 1'b1) begin n_bad++; $display("FAIL stray_seq: got %b expected 1", err_sequence); end
    tick();
    n_cmp++; if (n_seq != 1) begin n_bad++; $display("FAIL stray_count: got %0d expected 1", n_seq); end
  endtask

  task automatic test_framing();
    clear_errs();
    send(9'h1A5); send(9'h012);
    rx_framing_error = 1'b1;
    send(9'h034);
    for (int i = 0; i < 19; i++) tick();
    rx_framing_error = 1'b0;
    tick(); tick();
    n_cmp++; if (n_frm != 1) begin n_bad++; $display("FAIL framing_count: got %0d expected 1", n_frm); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL framing_valid: got %b expected 0", frame_valid); end
    send_frame(8'h3C, 8'h01, 8'h02, 8'h04);
    n_cmp++; if (frame_id !== 8'h3C) begin n_bad++; $display("FAIL framing_next_id: got 0x%0h expected 0x3c", frame_id); end
    chk("framing_next_payload", {8'h00, frame_payload}, 32'h00040201);
    pop_one();
  endtask

  task automatic test_overflow();
    clear_errs();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 8'(i), 8'h11, 8'h22);
    n_cmp++; if (frame_count !== 3'd4) begin n_bad++; $display("FAIL ovf_full: got %0d expected 4", frame_count); end
    send_frame(8'h14, 8'h04, 8'h11, 8'h22);
    n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b expected 1", err_overflow); end
    n_cmp++; if (frame_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d expected 4", frame_count); end
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", {24'h0, frame_id}, 32'h10 + i);
      chk("drain_payload", {8'h00, frame_payload}, {8'h00, 8'h22, 8'h11, 8'(i)});
      chk("drain_count", {29'h0, frame_count}, 32'(4 - i));
      tick();
    end
    frame_ready = 1'b0;
    n_cmp++; if (frame_count !== 3'd0) begin n_bad++; $display("FAIL drain_empty: got %0d expected 0", frame_count); end
    n_cmp++; if (n_ovf != 1) begin n_bad++; $display("FAIL ovf_total: got %0d expected 1", n_ovf); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 8'h05, 8'h06, 8'(i));
    clear_errs();
    send(9'h124); send(9'h005); send(9'h006); send(9'h004);
    rx_data = {1'b0, 8'h24 ^ 8'h05 ^ 8'h06 ^ 8'h04};
    rx_done = 1'b1;
    frame_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    frame_ready = 1'b0;
    n_cmp++; if (frame_count !== 3'd4) begin n_bad++; $display("FAIL pp_count: got %0d expected 4", frame_count); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL pp_ovf: got %b expected 0", err_overflow); end
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_drain_id", {24'h0, frame_id}, 32'h21 + i);
      tick();
    end
    frame_ready = 1'b0;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty: got %b expected 0", frame_valid); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h77, 8'h01, 8'h02, 8'h03);
    send(9'h1A5); send(9'h012);
    reset_n = 1'b0;
    tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b expected 0", frame_valid); end
    n_cmp++; if (frame_count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d expected 0", frame_count); end
    n_cmp++; if ({frame_id, frame_payload} !== 32'h0) begin n_bad++; $display("FAIL rmid_data: got 0x%0h expected 0", {frame_id, frame_payload}); end
    reset_n = 1'b1;
    tick();
    clear_errs();
    send(9'h034);
    n_cmp++; if (err_sequence !== 1'b1) begin n_bad++; $display("FAIL rmid_hunt: got %b expected 1", err_sequence); end
    tick();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_resync();
    test_framing();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_assembler.md
# uart_rx_frame_assembler

Receive-side framing stage directly downstream of the UART receiver. Consumes the receiver's 9-bit words, `done` strobes and `framing_error` flag, and assembles them into checksummed command frames: header word, fixed payload, checksum word. Valid frames are buffered in a small frame FIFO and presented to the controller over a valid/ready handshake. Malformed input produces single-cycle error pulses.

## Interface
- `PAYLOAD_WORDS`, default 3: payload bytes per frame; legal range is 1..8.
- `FIFO_DEPTH`, default 4: frame FIFO depth; must be a power of two, at least 2.
- `clock`  in  1  single system clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  9  receiver word. Bit 8 is the marker: 1 = header, 0 = payload or checksum. Bits [7:0] are the byte.
- `rx_done`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `rx_framing_error`  in  1  receiver framing error; may stay high for many cycles.
- `frame_valid`  out  1  FIFO is non-empty; head frame is presented.
- `frame_ready`  in  1  consumer accepts the head frame when `frame_valid` is also high.
- `frame_id`  out  8  header byte of the head frame.
- `frame_payload`  out  8*PAYLOAD_WORDS  payload of the head frame. Payload byte k is at bits [8k+7:8k].
- `frame_count`  out  $clog2(FIFO_DEPTH+1)  number of frames held.
- `err_sequence`  out  1  pulse: the marker bit was unexpected.
- `err_checksum`  out  1  pulse: checksum mismatch.
- `err_framing`  out  1  pulse: a rising edge on `rx_framing_error`.
- `err_overflow`  out  1  pulse: a good frame was dropped because the FIFO was full.

## Operation
- Running checksum: XOR of the header byte and all payload bytes, 8 bits wide.
- Frame word: a word presented with `rx_done` = 1. No other input activity affects the FSM, except framing errors.
- HUNT (state after reset):
  - Word with marker 1: latch `frame_id`, set checksum to the header byte, clear the payload index, go to PAYLOAD.
  - Word with marker 0: discard it, pulse `err_sequence`, stay in HUNT.
- PAYLOAD:
  - Word with marker 0: store the byte at the current index, XOR it into the checksum, increment the index.
  - After storing index PAYLOAD_WORDS-1, go to CHECK.
  - Word with marker 1: pulse `err_sequence`, discard the partial frame, treat the word as a new header (resync), stay in PAYLOAD with index 0.
- CHECK:
  - Word with marker 0 that equals the checksum: push the frame, then go to HUNT.
  - Word with marker 0 that differs: pulse `err_checksum`, drop the frame, go to HUNT.
  - Word with marker 1: pulse `err_sequence` and resync as in PAYLOAD.
- Framing error:
  - Rising edge of `rx_framing_error` in any state: pulse `err_framing`, discard the partial frame, go to HUNT.
  - While `rx_framing_error` is high, `rx_done` is ignored.
  - If `rx_framing_error` rises in the same cycle as `rx_done`, the framing error wins.
- FIFO:
  - Push succeeds if `frame_count` < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the frame is dropped and `err_overflow` pulses.
  - Pop occurs when `frame_valid` && `frame_ready`.
  - Push and pop in the same cycle leave `frame_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- `frame_id` and `frame_payload` are defined only while `frame_valid` = 1. They hold stable until popped.

## Timing
- Reset (`reset_n` = 0 at a clock edge):
  - State goes to HUNT; checksum, index and FIFO pointers clear.
  - All outputs read 0 in the next cycle, including `frame_id` and `frame_payload`.
  - Reset mid-frame or with a full FIFO discards everything. No error pulse is generated.
- Push latency: the checksum `rx_done` in cycle N gives `frame_valid` = 1 and the new `frame_count` in cycle N+1.
- Error pulses are registered. The causing event in cycle N gives a pulse of exactly one cycle in cycle N+1.
- Pop: acceptance in cycle N makes the next head (or `frame_valid` = 0) visible in cycle N+1.
- Back-to-back `rx_done` on consecutive cycles is supported with no lost words.
- `frame_valid` never depends combinationally on `frame_ready`.

## Test plan
All scenarios use the defaults (`PAYLOAD_WORDS` = 3, `FIFO_DEPTH` = 4).
- Good frame: words 0x1A5, 0x012, 0x034, 0x056, 0x0D5 -> one cycle after the last word, `frame_valid` = 1, `frame_id` = 0xA5, `frame_payload` = 0x563412, `frame_count` = 1, no error pulses.
- Bad checksum: same frame but checksum word 0x0D4 -> `err_checksum` pulses once; `frame_valid` stays 0.
- Resync: 0x1A5, 0x012, then 0x1B0, 0x001, 0x002, 0x003, 0x0B0 -> `err_sequence` pulses once; one frame with id 0xB0 and payload 0x030201. A stray 0x055 in HUNT -> `err_sequence` pulse.
- Framing abort: `rx_framing_error` held high for 20 cycles after 0x1A5, 0x012 (with an `rx_done` in the rising cycle) -> exactly one `err_framing` pulse. A following good frame is accepted.
- Overflow: five good frames with `frame_ready` = 0 -> `frame_count` = 4 and `err_overflow` pulses on the 5th. Then `frame_ready` = 1 drains 4 frames in order, one per cycle, with `frame_count` going 4→0.
- Full FIFO with a simultaneous push and pop -> the push is accepted, `frame_count` stays 4, and no `err_overflow` pulse. Reset asserted mid-frame -> all outputs read 0 the next cycle.
